// File: rtl/test_sequencer.sv
// test_sequencer: runs enabled self-checking sub-tests one at a time with a
// per-test watchdog, accumulates a saturating error total and reports pass/fail.
module test_sequencer #(
  parameter int unsigned NUM_TESTS           = 10,
  parameter int unsigned ERR_W               = 16,
  parameter int unsigned TOTAL_ERR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES      = 1000,
  parameter int unsigned CONTINUE_ON_TIMEOUT = 0,
  localparam int unsigned IDX_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_TESTS-1:0]         test_mask,
  output logic [NUM_TESTS-1:0]         test_start,
  input  logic [NUM_TESTS-1:0]         test_done,
  input  logic [NUM_TESTS*ERR_W-1:0]   test_err,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [TOTAL_ERR_W-1:0]       total_errors,
  output logic                         timed_out,
  output logic [IDX_W-1:0]             timeout_idx,
  output logic [IDX_W-1:0]             cur_idx
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned SUM_W = TOTAL_ERR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TESTS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_ACCUM  = 3'd4,
    S_FINISH = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       cur_idx_q, cur_idx_d;
  logic [NUM_TESTS-1:0]   mask_q, mask_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [ERR_W-1:0]       err_q, err_d;
  logic [TOTAL_ERR_W-1:0] total_q, total_d;
  logic                   timed_out_q, timed_out_d;
  logic [IDX_W-1:0]       timeout_idx_q, timeout_idx_d;
  logic                   pass_q, pass_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic [NUM_TESTS-1:0]   test_start_q, test_start_d;

  logic [ERR_W-1:0]       err_sel;
  logic                   done_sel;
  logic [SUM_W-1:0]       acc_sum, tmo_sum;
  logic [TOTAL_ERR_W-1:0] acc_sat, tmo_sat;
  logic                   advance;

  // Pick the error count and completion flag of the test currently running
  always_comb begin
    err_sel = '0;
    for (int unsigned i = 0; i < NUM_TESTS; i++) begin
      if (cur_idx_q == IDX_W'(i)) begin
        err_sel = test_err[i*ERR_W +: ERR_W];
      end
    end
    done_sel = test_done[cur_idx_q];
  end

  // Saturating accumulate of a test's error count and of a single timeout
  always_comb begin
    acc_sum = SUM_W'(total_q) + SUM_W'(err_q);
    tmo_sum = SUM_W'(total_q) + SUM_W'(1);
    acc_sat = acc_sum[TOTAL_ERR_W] ? '1 : acc_sum[TOTAL_ERR_W-1:0];
    tmo_sat = tmo_sum[TOTAL_ERR_W] ? '1 : tmo_sum[TOTAL_ERR_W-1:0];
  end

  // Next-state and registered-output logic of the run sequencer
  always_comb begin
    state_d       = state_q;
    cur_idx_d     = cur_idx_q;
    mask_d        = mask_q;
    timer_d       = timer_q;
    err_d         = err_q;
    total_d       = total_q;
    timed_out_d   = timed_out_q;
    timeout_idx_d = timeout_idx_q;
    pass_d        = pass_q;
    done_d        = done_q;
    busy_d        = busy_q;
    test_start_d  = '0;
    advance       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d        = test_mask;
          total_d       = '0;
          timed_out_d   = 1'b0;
          timeout_idx_d = '0;
          pass_d        = 1'b0;
          done_d        = 1'b0;
          busy_d        = 1'b1;
          cur_idx_d     = '0;
          state_d       = S_SELECT;
        end
      end
      S_SELECT: begin
        if (mask_q[cur_idx_q]) begin
          state_d = S_LAUNCH;
        end else begin
          advance = 1'b1;
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        if (done_sel) begin
          err_d   = err_sel;
          state_d = S_ACCUM;
        end else if (timer_q == TMR_LAST) begin
          total_d     = tmo_sat;
          timed_out_d = 1'b1;
          if (!timed_out_q) begin
            timeout_idx_d = cur_idx_q;
          end
          if (CONTINUE_ON_TIMEOUT != 0) begin
            advance = 1'b1;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_ACCUM: begin
        total_d = acc_sat;
        advance = 1'b1;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Step to the next index, or wrap up after the last one
    if (advance) begin
      if (cur_idx_q == LAST_IDX) begin
        state_d = S_FINISH;
      end else begin
        cur_idx_d = cur_idx_q + IDX_W'(1);
        state_d   = S_SELECT;
      end
    end

    // Report the result as FINISH is entered so done/pass are visible in it
    if ((state_d == S_FINISH) && (state_q != S_FINISH)) begin
      done_d = 1'b1;
      busy_d = 1'b0;
      pass_d = (total_d == '0) && !timed_out_d;
    end

    // Launch pulse is registered so it is high exactly during LAUNCH
    if (state_d == S_LAUNCH) begin
      test_start_d = NUM_TESTS'(1) << cur_idx_d;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_idx_q     <= '0;
      mask_q        <= '0;
      timer_q       <= '0;
      err_q         <= '0;
      total_q       <= '0;
      timed_out_q   <= 1'b0;
      timeout_idx_q <= '0;
      pass_q        <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      test_start_q  <= '0;
    end else begin
      state_q       <= state_d;
      cur_idx_q     <= cur_idx_d;
      mask_q        <= mask_d;
      timer_q       <= timer_d;
      err_q         <= err_d;
      total_q       <= total_d;
      timed_out_q   <= timed_out_d;
      timeout_idx_q <= timeout_idx_d;
      pass_q        <= pass_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      test_start_q  <= test_start_d;
    end
  end

  assign test_start   = test_start_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign total_errors = total_q;
  assign timed_out    = timed_out_q;
  assign timeout_idx  = timeout_idx_q;
  assign cur_idx      = cur_idx_q;

endmodule

// File: doc/test_sequencer.md
Name: test_sequencer

Overview:
Synthesizable on-chip successor to the simulation-only integrated test runner. It launches up to NUM_TESTS self-checking sub-blocks (BIST engines, loopback checkers) one after another and applies a per-test watchdog timeout. It accumulates their error counts into a saturating total and reports pass/fail. It sits between the PS-facing register slave, which provides start and mask, and the per-block checkers.

Parameters:
NUM_TESTS, 10, number of sub-tests (>=1)
ERR_W, 16, width of each sub-test error count
TOTAL_ERR_W, 32, width of accumulated error total (>= ERR_W)
TIMEOUT_CYCLES, 1000, WAIT cycles allowed per test before timeout (>=1)
CONTINUE_ON_TIMEOUT, 0, 0 = abort the run at the first timeout; 1 = count the timeout and continue to the next test

Ports:
clk  in  1  single clock
rst  in  1  synchronous active-high reset
start  in  1  run request; sampled only in IDLE
test_mask  in  NUM_TESTS  bit i=1 enables test i; sampled when start is accepted
test_start  out  NUM_TESTS  one-cycle launch pulse to test i
test_done  in  NUM_TESTS  completion pulse/level from test i
test_err  in  NUM_TESTS*ERR_W  error count of test i, slice [i*ERR_W +: ERR_W]; valid when test_done[i]=1
busy  out  1  high from the cycle after start is accepted until done rises
done  out  1  level; high after a run completes, cleared by the next accepted start or rst
pass  out  1  valid when done=1; 1 iff total_errors==0 and timed_out==0
total_errors  out  TOTAL_ERR_W  saturating sum of errors plus one per timeout
timed_out  out  1  sticky for the run; at least one test timed out
timeout_idx  out  $clog2(NUM_TESTS)  index of the first test that timed out
cur_idx  out  $clog2(NUM_TESTS)  index currently selected or running

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE, all outputs 0, timer=0, mask register=0. Applies from any state, including mid-WAIT; test_start is never high in the cycle after rst.
- States: IDLE, SELECT, LAUNCH, WAIT, ACCUM, FINISH.
- IDLE: start=1 -> latch test_mask, clear total_errors/timed_out/timeout_idx/pass/done, cur_idx=0, go to SELECT.
- start is ignored in every other state.
- SELECT (1 cycle per index): mask[cur_idx]=1 -> LAUNCH. Otherwise, if cur_idx==NUM_TESTS-1 -> FINISH, else cur_idx++ and stay in SELECT.
- LAUNCH (1 cycle): test_start[cur_idx]=1, all other bits 0; timer=0; -> WAIT.
- WAIT: timer increments each cycle. test_done of any index other than cur_idx is ignored.
  - test_done[cur_idx]=1 -> register the cur_idx slice of test_err, go to ACCUM.
  - Else, if timer==TIMEOUT_CYCLES-1 -> timeout: add 1 to total_errors (saturating); set timed_out; record timeout_idx only on the first timeout of the run.
    - CONTINUE_ON_TIMEOUT=0 -> FINISH.
    - CONTINUE_ON_TIMEOUT=1 -> advance as in ACCUM.
  - test_done in the same cycle as the timeout: done wins, no timeout.
- ACCUM (1 cycle): total_errors = min(total_errors + err, 2^TOTAL_ERR_W-1), with err zero-extended. Then cur_idx==NUM_TESTS-1 -> FINISH, else cur_idx++ and go to SELECT.
- FINISH (1 cycle): done=1, busy=0, pass computed -> IDLE. done/pass/total_errors hold until the next accepted start.
- Mask all zero: FINISH is reached after NUM_TESTS SELECT cycles; pass=1, total=0.
- Latency for an enabled test whose done arrives k cycles after its test_start pulse (k>=1): total_errors updates k+1 cycles after that pulse.

Test Plan:
1. NUM_TESTS=4, mask=4'hF, each test pulses done 5 cycles after its test_start with errs 0,2,0,1 -> exactly one test_start pulse per test in order 0..3; done=1, total_errors=3, pass=0, timed_out=0.
2. Same run with all errs 0 -> pass=1, total_errors=0; then start a second run with errs 7,0,0,0 -> total_errors cleared on start and ends at 7.
3. TIMEOUT_CYCLES=1000, CONTINUE_ON_TIMEOUT=0, test 2 never asserts done, errs 1,1 on tests 0,1 -> timeout exactly 1000 WAIT cycles after test_start[2]; total_errors=3, timed_out=1, timeout_idx=2; test_start[3] never pulses.
4. Same with CONTINUE_ON_TIMEOUT=1, test 3 returns err 4 -> test_start[3] pulses; total_errors=7, timeout_idx=2, pass=0.
5. mask=4'b0101 -> only test_start[0] and test_start[2] pulse; test_done[1] asserted spuriously during test 0's WAIT is ignored. mask=0 -> done within NUM_TESTS+2 cycles, pass=1.
6. rst pulsed mid-WAIT of test 1 -> the next cycle busy=0, done=0, total_errors=0, test_start=0. start held high while busy -> no restart. TOTAL_ERR_W=ERR_W=4 with errs 15,15 -> total_errors saturates at 15.
